// File: rtl/tube_hit_scheduler_if.sv
// Readout and control bundle for the tube hit scheduler.
// The master side is the run controller plus downstream event buffer; the slave side is the scheduler.
interface tube_hit_scheduler_if #(
    parameter int N_TUBES  = 4,
    parameter int TS_WIDTH = 8
);
    localparam int CH_W = $clog2(N_TUBES);

    logic                enable;
    logic [N_TUBES-1:0]  tube_signal;
    logic [TS_WIDTH-1:0] counter;
    logic                hit_valid;
    logic                hit_ready;
    logic [CH_W-1:0]     hit_channel;
    logic [TS_WIDTH-1:0] hit_time;
    logic [N_TUBES-1:0]  overflow;
    logic                clear_overflow;

    modport master (
        output enable, tube_signal, hit_ready, clear_overflow,
        input  counter, hit_valid, hit_channel, hit_time, overflow
    );

    modport slave (
        input  enable, tube_signal, hit_ready, clear_overflow,
        output counter, hit_valid, hit_channel, hit_time, overflow
    );
endinterface

// File: rtl/tube_hit_scheduler.sv
// Timestamps synchronized tube pulses into per-channel slots and drains them
// round-robin onto a single valid/ready readout port.
module tube_hit_scheduler #(
    parameter int N_TUBES  = 4,
    parameter int TS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tube_hit_scheduler_if.slave  bus
);
    localparam int CH_W = $clog2(N_TUBES);

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } state_t;

    state_t              state_q, state_d;
    logic [TS_WIDTH-1:0] counter_q, counter_d;
    logic [N_TUBES-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [N_TUBES-1:0]  pending_q, pending_d;
    logic [TS_WIDTH-1:0] slot_q [N_TUBES];
    logic [TS_WIDTH-1:0] slot_d [N_TUBES];
    logic [N_TUBES-1:0]  overflow_q, overflow_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic                hit_valid_q, hit_valid_d;
    logic [CH_W-1:0]     hit_channel_q, hit_channel_d;
    logic [TS_WIDTH-1:0] hit_time_q, hit_time_d;

    logic [N_TUBES-1:0]  edge_det;
    logic [N_TUBES-1:0]  hs_mask;
    logic [N_TUBES-1:0]  lost;
    logic                handshake;
    logic                grant_found;
    logic [CH_W-1:0]     grant_ch;
    logic [CH_W-1:0]     cand;

    always_comb begin
        counter_d = bus.enable ? counter_q + 1'b1 : counter_q;
        s1_d      = bus.tube_signal;
        s2_d      = s1_q;
        s3_d      = s2_q;
        edge_det  = s2_q & ~s3_q;
    end

    // A hit landing on the channel that is completing its handshake this
    // cycle replaces the slot instead of counting as a collision.
    always_comb begin
        handshake = (state_q == ST_OFFER) && bus.hit_ready;
        hs_mask   = '0;
        if (handshake) hs_mask[hit_channel_q] = 1'b1;
        pending_d = pending_q;
        slot_d    = slot_q;
        lost      = '0;
        for (int i = 0; i < N_TUBES; i++) begin
            if (hs_mask[i]) pending_d[i] = 1'b0;
            if (edge_det[i] && bus.enable) begin
                if (pending_q[i] && !hs_mask[i]) begin
                    lost[i] = 1'b1;
                end else begin
                    slot_d[i]    = counter_q;
                    pending_d[i] = 1'b1;
                end
            end
        end
        overflow_d = (bus.clear_overflow ? '0 : overflow_q) | lost;
    end

    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int off = 1; off <= N_TUBES; off++) begin
            cand = CH_W'((int'(ptr_q) + off) % N_TUBES);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hit_valid_d   = hit_valid_q;
        hit_channel_d = hit_channel_q;
        hit_time_d    = hit_time_q;
        case (state_q)
            ST_IDLE: begin
                hit_valid_d = 1'b0;
                if (grant_found) begin
                    hit_channel_d = grant_ch;
                    hit_time_d    = slot_q[grant_ch];
                    hit_valid_d   = 1'b1;
                    state_d       = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (handshake) begin
                    hit_valid_d = 1'b0;
                    ptr_d       = hit_channel_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Synchronizer flops reset high so a level held across reset is not a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            s1_q          <= '1;
            s2_q          <= '1;
            s3_q          <= '1;
            pending_q     <= '0;
            overflow_q    <= '0;
            ptr_q         <= CH_W'(N_TUBES - 1);
            hit_valid_q   <= 1'b0;
            hit_channel_q <= '0;
            hit_time_q    <= '0;
            for (int i = 0; i < N_TUBES; i++) slot_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            ptr_q         <= ptr_d;
            hit_valid_q   <= hit_valid_d;
            hit_channel_q <= hit_channel_d;
            hit_time_q    <= hit_time_d;
            for (int i = 0; i < N_TUBES; i++) slot_q[i] <= slot_d[i];
        end
    end

    assign bus.counter     = counter_q;
    assign bus.hit_valid   = hit_valid_q;
    assign bus.hit_channel = hit_channel_q;
    assign bus.hit_time    = hit_time_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_tube_hit_scheduler.sv
// Directed bench for tube_hit_scheduler: cycle tables for basic capture and
// round-robin, hand sequences for overflow, handshake collision, wrap/enable and reset.
module tb_tube_hit_scheduler;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    tube_hit_scheduler_if #(.N_TUBES(N), .TS_WIDTH(W)) bus();

    tube_hit_scheduler #(.N_TUBES(N), .TS_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    logic [W-1:0] exp_cnt = '0;
    logic [W-1:0] t_exp;
    logic [W-1:0] t_exp2;

    typedef struct {
        bit           do_reset;
        logic [N-1:0] tube;
        bit           rdy;
        bit           exp_valid;
        logic [1:0]   exp_ch;
        logic [W-1:0] exp_time;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_row(bit do_reset, logic [N-1:0] tube, bit rdy,
                                    bit exp_valid, logic [1:0] exp_ch, logic [W-1:0] exp_time);
        vec_t v;
        v.do_reset  = do_reset;
        v.tube      = tube;
        v.rdy       = rdy;
        v.exp_valid = exp_valid;
        v.exp_ch    = exp_ch;
        v.exp_time  = exp_time;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string tag, input bit ev, input logic [1:0] ch,
                             input logic [W-1:0] t, input logic [N-1:0] ovf);
        check_output({tag, " counter"},  32'(bus.counter),   32'(exp_cnt));
        check_output({tag, " valid"},    32'(bus.hit_valid), 32'(ev));
        check_output({tag, " overflow"}, 32'(bus.overflow),  32'(ovf));
        if (ev) begin
            check_output({tag, " channel"}, 32'(bus.hit_channel), 32'(ch));
            check_output({tag, " time"},    32'(bus.hit_time),    32'(t));
        end
    endtask

    task automatic tick();
        logic en_now;
        en_now = bus.enable;
        @(posedge clk);
        #1;
        if (en_now) exp_cnt = exp_cnt + 1'b1;
    endtask

    // Reset is pulsed between edges so its effect is visible without a clock.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        exp_cnt = '0;
        check_bus("reset", 1'b0, 2'd0, '0, '0);
        check_output("reset channel", 32'(bus.hit_channel), 32'd0);
        check_output("reset time",    32'(bus.hit_time),    32'd0);
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.do_reset) do_reset();
        bus.enable      = 1'b1;
        bus.tube_signal = v.tube;
        bus.hit_ready   = v.rdy;
        tick();
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        bus.tube_signal = mask;
        repeat (3) tick();
        bus.tube_signal = '0;
        repeat (2) tick();
    endtask

    initial begin
        rst                = 1'b1;
        bus.enable         = 1'b0;
        bus.tube_signal    = '0;
        bus.hit_ready      = 1'b0;
        bus.clear_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic: tube 2 raised with counter 10 visible -> time 12 after 4th edge.
        add_row(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 9; i++) add_row(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 3; i++) add_row(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 8'd0);
        add_row(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 8'd12);
        add_row(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);
        add_row(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);

        // Round-robin from a fresh pointer, then a single ch1 hit, then all again.
        add_row(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 2; i++) add_row(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 3; i++) add_row(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            add_row(1'b0, 4'b0000, 1'b1, 1'b1, 2'(i), 8'd5);
            add_row(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);
        end
        for (int i = 0; i < 3; i++) add_row(1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 8'd0);
        add_row(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'd16);
        add_row(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 3; i++) add_row(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 8'd0);
        add_row(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 8'd21);
        add_row(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);
        add_row(1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 8'd21);
        add_row(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);
        add_row(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 8'd21);
        add_row(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);
        add_row(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'd21);
        add_row(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_bus($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_ch,
                      vecs[i].exp_time, 4'b0000);
        end

        // Backpressure and overflow on channel 1.
        do_reset();
        bus.enable    = 1'b1;
        bus.hit_ready = 1'b0;
        repeat (3) tick();
        t_exp = exp_cnt + 8'd2;
        pulse(4'b0010);
        check_bus("bp first", 1'b1, 2'd1, t_exp, 4'b0000);
        pulse(4'b0010);
        check_bus("bp collide", 1'b1, 2'd1, t_exp, 4'b0010);
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        check_bus("bp clear", 1'b1, 2'd1, t_exp, 4'b0000);
        bus.tube_signal = 4'b0010;
        repeat (2) tick();
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        check_bus("bp set wins", 1'b1, 2'd1, t_exp, 4'b0010);
        bus.tube_signal = '0;
        repeat (2) tick();
        bus.hit_ready = 1'b1;
        tick();
        check_bus("bp drained", 1'b0, 2'd0, '0, 4'b0010);
        tick();
        check_bus("bp no extra", 1'b0, 2'd0, '0, 4'b0010);

        // Channel 0 hit landing on its own handshake edge.
        do_reset();
        bus.enable    = 1'b1;
        bus.hit_ready = 1'b0;
        repeat (3) tick();
        t_exp = exp_cnt + 8'd2;
        pulse(4'b0001);
        check_bus("hs first", 1'b1, 2'd0, t_exp, 4'b0000);
        t_exp2 = exp_cnt + 8'd2;
        bus.tube_signal = 4'b0001;
        repeat (2) tick();
        bus.hit_ready = 1'b1;
        tick();
        bus.tube_signal = '0;
        bus.hit_ready   = 1'b0;
        check_bus("hs edge", 1'b0, 2'd0, '0, 4'b0000);
        tick();
        check_bus("hs second", 1'b1, 2'd0, t_exp2, 4'b0000);
        bus.hit_ready = 1'b1;
        tick();
        check_bus("hs done", 1'b0, 2'd0, '0, 4'b0000);

        // Counter wrap, then ENABLE low: counter holds, new hits ignored, pending drains.
        do_reset();
        bus.enable    = 1'b1;
        bus.hit_ready = 1'b0;
        for (int i = 0; i < 300 && exp_cnt != 8'd254; i++) tick();
        check_output("wrap start", 32'(bus.counter), 32'd254);
        bus.tube_signal = 4'b0110;
        repeat (2) tick();
        check_output("wrap zero", 32'(bus.counter), 32'd0);
        tick();
        bus.tube_signal = '0;
        repeat (2) tick();
        check_bus("wrap hit", 1'b1, 2'd1, 8'd0, 4'b0000);
        bus.enable = 1'b0;
        pulse(4'b1000);
        check_bus("dis hold", 1'b1, 2'd1, 8'd0, 4'b0000);
        bus.hit_ready = 1'b1;
        tick();
        check_bus("dis hs1", 1'b0, 2'd0, '0, 4'b0000);
        tick();
        check_bus("dis ch2", 1'b1, 2'd2, 8'd0, 4'b0000);
        tick();
        check_bus("dis hs2", 1'b0, 2'd0, '0, 4'b0000);
        tick();
        check_bus("dis ignored", 1'b0, 2'd0, '0, 4'b0000);

        // Reset during an offer with an overflow set and tube 3 held high across release.
        bus.hit_ready = 1'b0;
        do_reset();
        bus.enable = 1'b1;
        repeat (3) tick();
        t_exp = exp_cnt + 8'd2;
        pulse(4'b1000);
        pulse(4'b1000);
        check_bus("mid offer", 1'b1, 2'd3, t_exp, 4'b1000);
        bus.tube_signal = 4'b1000;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            check_bus($sformatf("held high %0d", i), 1'b0, 2'd0, '0, 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
